// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: PC/ROM inputs, handshake switch, and the IR/stall outputs toward PC and decode.
interface fetch_stage_if #(
  parameter int Psize  = 5,
  parameter int Isize  = 24,
  parameter int SCNT_W = 8
);
  logic [Psize-1:0]  PCin;
  logic [Isize-1:0]  ProgData;
  logic              Handshake;
  logic              PCHold;
  logic [Isize-1:0]  Instr;
  logic [Psize-1:0]  InstrPC;
  logic              ExecEn;
  logic              Halted;
  logic [SCNT_W-1:0] StallCnt;

  modport master (
    output PCin, ProgData, Handshake,
    input  PCHold, Instr, InstrPC, ExecEn, Halted, StallCnt
  );

  modport slave (
    input  PCin, ProgData, Handshake,
    output PCHold, Instr, InstrPC, ExecEn, Halted, StallCnt
  );
endinterface

// File: rtl/fetch_stage.sv
// One-stage instruction fetch register with WAIT (switch press/release) and HALT stall control.
module fetch_stage #(
  parameter int         Psize   = 5,
  parameter int         Isize   = 24,
  parameter logic [2:0] OP_WAIT = 3'b110,
  parameter logic [2:0] OP_HALT = 3'b111,
  parameter int         SCNT_W  = 8
) (
  input logic          clk,
  input logic          Reset,
  fetch_stage_if.slave bus
);

  typedef enum logic [1:0] {RUN, WAIT_HI, WAIT_LO, HALT} state_t;

  state_t            state, next_state;
  logic              hs_meta, hs_sync;
  logic [Isize-1:0]  ir_p1;
  logic [Psize-1:0]  pc_p1;
  logic              vld_p1;
  logic              halted;
  logic [SCNT_W-1:0] stall_cnt;
  logic              is_wait, is_halt, pc_hold;

  function automatic logic [SCNT_W-1:0] sat_inc(input logic [SCNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign is_wait = vld_p1 && (ir_p1[Isize-1 -: 3] == OP_WAIT);
  assign is_halt = vld_p1 && (ir_p1[Isize-1 -: 3] == OP_HALT);

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      hs_meta <= 1'b0;
      hs_sync <= 1'b0;
    end else begin
      hs_meta <= bus.Handshake;
      hs_sync <= hs_meta;
    end
  end

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) state <= RUN;
    else       state <= next_state;
  end

  // WAIT is a full press/release: leave WAIT_HI on the press, WAIT_LO on the release
  always_comb begin
    next_state = state;
    pc_hold    = 1'b0;
    case (state)
      RUN: begin
        if (is_halt) begin
          next_state = HALT;
          pc_hold    = 1'b1;
        end else if (is_wait) begin
          next_state = WAIT_HI;
          pc_hold    = 1'b1;
        end
      end
      WAIT_HI: begin
        pc_hold = 1'b1;
        if (hs_sync) next_state = WAIT_LO;
      end
      WAIT_LO: begin
        if (hs_sync) pc_hold    = 1'b1;
        else         next_state = RUN;
      end
      HALT:    pc_hold = 1'b1;
      default: next_state = RUN;
    endcase
  end

  // Fetch stage boundary: IR holds the word at PC-1 since the PC advances on the same edge
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      ir_p1  <= '0;
      pc_p1  <= '0;
      vld_p1 <= 1'b0;
    end else if (!pc_hold) begin
      ir_p1  <= bus.ProgData;
      pc_p1  <= bus.PCin;
      vld_p1 <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      halted    <= 1'b0;
      stall_cnt <= '0;
    end else begin
      halted <= (next_state == HALT);
      if (pc_hold) stall_cnt <= sat_inc(stall_cnt);
    end
  end

  assign bus.PCHold   = pc_hold;
  assign bus.Instr    = ir_p1;
  assign bus.InstrPC  = pc_p1;
  assign bus.ExecEn   = vld_p1 && (state == RUN) && !is_wait && !is_halt;
  assign bus.Halted   = halted;
  assign bus.StallCnt = stall_cnt;

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction fetch register and stall controller. Sits directly downstream of the program counter and program ROM.
- Captures the ROM word addressed by the PC into an instruction register (IR) and hands it to decode/execute with a one-shot execute enable.
- Generates the PC hold signal for WAIT (press-and-release of a handshake switch) and HALT instructions.

Parameters:
- Psize, 5, PC/ROM address width (up to 32 instructions).
- Isize, 24, instruction word width.
- OP_WAIT, 3'b110, value of IR[Isize-1 -: 3] that marks a WAIT instruction.
- OP_HALT, 3'b111, value of IR[Isize-1 -: 3] that marks a HALT instruction.
- SCNT_W, 8, width of the stall cycle counter.

Ports:
- clk  in  1  system clock; all state changes on posedge.
- Reset  in  1  asynchronous, active-high reset.
- PCin  in  Psize  current PC value; also drives the ROM address.
- ProgData  in  Isize  combinational ROM output for address PCin.
- Handshake  in  1  asynchronous handshake switch.
- PCHold  out  1  to PC; 1 freezes the PC.
- Instr  out  Isize  IR contents.
- InstrPC  out  Psize  address Instr was fetched from.
- ExecEn  out  1  1 for exactly one cycle per executable (non-WAIT/HALT) instruction.
- Halted  out  1  HALT reached.
- StallCnt  out  SCNT_W  total stall cycles since reset, saturating.

Behaviour:
- Reset (async, Reset=1):
  - IR=0, InstrPC=0, IRValid=0, state=RUN, Halted=0, StallCnt=0.
  - Synchronizer flops=0.
  - Reset mid-WAIT or in HALT aborts immediately to these values.
- Handshake input:
  - 2-flop synchronizer producing HsS. No debounce.
  - Decisions use HsS only, so there are 2 cycles of latency from the pin.
- Advance:
  - Advance = ~PCHold.
  - On posedge with Advance=1: IR<=ProgData, InstrPC<=PCin, IRValid<=1.
  - The PC increments on the same edge, so IR always holds the word at PC-1. This is a one-stage fetch pipeline.
- Decode: isWait = IRValid & IR[top3]==OP_WAIT; isHalt = IRValid & IR[top3]==OP_HALT.
- State machine, states RUN, WAIT_HI, WAIT_LO, HALT:
  - RUN: isHalt -> HALT; isWait -> WAIT_HI; else stay.
  - WAIT_HI: HsS==1 -> WAIT_LO; else stay.
  - WAIT_LO: HsS==0 -> RUN. On this same edge Advance=1, so the IR loads the instruction following the WAIT.
  - HALT: absorbing; left only via Reset.
- PCHold (combinational from state, IR, HsS), PCHold=1 when any of:
  - state==RUN & (isWait | isHalt);
  - state==WAIT_HI;
  - state==WAIT_LO & HsS==1;
  - state==HALT.
- If Handshake is already high when a WAIT enters the IR: WAIT_HI exits on the first cycle, then release waits for HsS low. A stuck-high switch stalls indefinitely.
- ExecEn = IRValid & state==RUN & ~isWait & ~isHalt.
  - Consecutive ALU instructions give ExecEn=1 on consecutive cycles.
  - ExecEn=0 while IRValid=0 (first cycle after reset).
- Halted = (state==HALT), registered.
- StallCnt: +1 on each posedge where PCHold=1. Saturates at 2^SCNT_W-1; no wrap.
- PC wrap-around (31->0) is transparent: InstrPC follows PCin.
- Instr/InstrPC are stable during any stall.

Test Plan:
- Reset release, ROM[0..2] = ALU ops A,B,C: cycle1 IRValid=0, ExecEn=0, PCHold=0; cycles 2-4 Instr=A,B,C, InstrPC=0,1,2, ExecEn=1 each cycle; StallCnt=0.
- ROM[1]=WAIT (0xC00000), Handshake low for 10 cycles then high for 5 then low:
  - PCHold=1 from the cycle IR=WAIT; ExecEn=0 throughout.
  - PC stays 2; Instr=WAIT.
  - Release occurs 2 cycles after the Handshake falling edge; next cycle Instr=ROM[2], ExecEn=1.
  - StallCnt equals the held cycle count (bench-computed).
- WAIT with Handshake already high: no advance until Handshake goes low; exactly one instruction executes after release.
- ROM[3]=HALT (0xE00000): Halted=1 one cycle after IR=HALT; PCHold=1 forever; ExecEn=0; Handshake toggles ignored.
- Assert Reset for 1 cycle mid-WAIT_LO and during HALT: all outputs return to reset values immediately (async); refetch from PC=0.
- Force 300 stall cycles: StallCnt saturates at 255.
- PC wrap: 32 ALU instructions, no stalls; InstrPC goes 31 then 0, ExecEn remains continuously 1.
